// File: rtl/log_mult_pkg.sv
// Constants shared by the log-domain multiplier blocks (log_conv and antilog_conv).
package log_mult_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_KEEP_WIDTH = 6;

endpackage : log_mult_pkg

// File: rtl/antilog_shift.sv
// Combinational antilog core: product = ({1,f} << E) >> KEEP_WIDTH, truncated, in 2*WIDTH bits.
module antilog_shift
  import log_mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  localparam int EW        = $clog2(WIDTH) + 1
) (
  input  logic [EW-1:0]         e,
  input  logic [KEEP_WIDTH:0]   m,
  output logic [2*WIDTH-1:0]    product
);

  localparam logic [EW-1:0] KEEP = EW'(KEEP_WIDTH);

  logic [2*WIDTH-1:0] m_ext;

  assign m_ext = {{(2*WIDTH-KEEP_WIDTH-1){1'b0}}, m};

  // Splitting on E >= KEEP_WIDTH folds the net shift into one direction,
  // so fraction bits below bit 0 simply fall off the right-hand shift.
  always_comb begin
    product = '0;
    if (e >= KEEP) begin
      product = m_ext << (e - KEEP);
    end else begin
      product = m_ext >> (KEEP - e);
    end
  end

endmodule : antilog_shift

// File: rtl/antilog_conv.sv
// Two-stage antilog converter: decodes summed characteristic/fraction into an approximate product.
module antilog_conv
  import log_mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  localparam int EW        = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_zero,
  input  logic [EW-1:0]         sum_k,
  input  logic [KEEP_WIDTH:0]   sum_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    product
);

  // Handshake: a beat moves on a rising edge exactly when valid && ready;
  // valid holds with its data until taken, ready may follow out_ready combinationally.

  typedef struct packed {
    logic [EW-1:0]       e;
    logic [KEEP_WIDTH:0] m;
    logic                zero;
  } s1_rec_t;

  s1_rec_t            s1;
  logic               s1_valid;
  logic               s2_load;
  logic               s1_load;
  logic [EW-1:0]      e_dec;
  logic [2*WIDTH-1:0] shifted;

  // The carry out of the fraction sum bumps the exponent by one.
  assign e_dec    = sum_k + EW'(sum_x[KEEP_WIDTH]);
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1.e    <= e_dec;
      s1.m    <= {1'b1, sum_x[KEEP_WIDTH-1:0]};
      s1.zero <= in_zero;
    end
  end

  antilog_shift #(
    .WIDTH      (WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_shift (
    .e       (s1.e),
    .m       (s1.m),
    .product (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        product <= s1.zero ? '0 : shifted;
      end
    end
  end

endmodule : antilog_conv
